// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among reservation stations with
// a registered broadcast of tag, value and destination, plus a confirm pulse.
module cdb_arbiter #(
    parameter int N_RS   = 4,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3,
    parameter int REG_W  = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_RS-1:0]          Req,
    input  logic [N_RS*DATA_W-1:0]   Result,
    input  logic [N_RS*REG_W-1:0]    R_target,
    output logic [N_RS-1:0]          CDB_confirm,
    output logic                     CDB_valid,
    output logic [TAG_W-1:0]         CDB_tag,
    output logic [DATA_W-1:0]        CDB_data,
    output logic [REG_W-1:0]         CDB_dest,
    output logic                     CDB_we,
    output logic [TAG_W-1:0]         Ptr
);

    logic [N_RS-1:0] elig;
    logic            win_found;
    int              win_idx;
    int              scan_idx;

    // The station confirmed this cycle may still hold Req; it must not win twice in a row.
    assign elig = Req & ~CDB_confirm;

    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        scan_idx  = 0;
        for (int k = 0; k < N_RS; k++) begin
            scan_idx = int'(Ptr) + k;
            if (scan_idx >= N_RS) begin
                scan_idx = scan_idx - N_RS;
            end
            if (!win_found && elig[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            CDB_confirm <= '0;
            CDB_valid   <= 1'b0;
            CDB_we      <= 1'b0;
            CDB_tag     <= '0;
            CDB_data    <= '0;
            CDB_dest    <= '0;
            Ptr         <= '0;
        end else if (win_found) begin
            CDB_confirm <= N_RS'(1) << win_idx;
            CDB_valid   <= 1'b1;
            CDB_we      <= 1'b1;
            CDB_tag     <= TAG_W'(win_idx + 1);
            CDB_data    <= Result[win_idx*DATA_W +: DATA_W];
            CDB_dest    <= R_target[win_idx*REG_W +: REG_W];
            Ptr         <= (win_idx == N_RS - 1) ? '0 : TAG_W'(win_idx + 1);
        end else begin
            // Tag/data/dest hold so snoopers see a stable bus while idle.
            CDB_confirm <= '0;
            CDB_valid   <= 1'b0;
            CDB_we      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;

    logic        Clock;
    logic        Reset;
    logic [3:0]  Req;
    logic [63:0] Result;
    logic [11:0] R_target;
    logic [3:0]  CDB_confirm;
    logic        CDB_valid;
    logic [2:0]  CDB_tag;
    logic [15:0] CDB_data;
    logic [2:0]  CDB_dest;
    logic        CDB_we;
    logic [2:0]  Ptr;

    int n_total = 0;
    int n_pass  = 0;

    cdb_arbiter #(.N_RS(4), .DATA_W(16), .TAG_W(3), .REG_W(3)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Req         (Req),
        .Result      (Result),
        .R_target    (R_target),
        .CDB_confirm (CDB_confirm),
        .CDB_valid   (CDB_valid),
        .CDB_tag     (CDB_tag),
        .CDB_data    (CDB_data),
        .CDB_dest    (CDB_dest),
        .CDB_we      (CDB_we),
        .Ptr         (Ptr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] conf, input logic [2:0] t,
                             input logic [15:0] d, input logic [2:0] dst, input logic [2:0] p);
        chk({tag, ".confirm"}, 32'(CDB_confirm), 32'(conf));
        chk({tag, ".valid"},   32'(CDB_valid),   32'(1));
        chk({tag, ".we"},      32'(CDB_we),      32'(1));
        chk({tag, ".tag"},     32'(CDB_tag),     32'(t));
        chk({tag, ".data"},    32'(CDB_data),    32'(d));
        chk({tag, ".dest"},    32'(CDB_dest),    32'(dst));
        chk({tag, ".ptr"},     32'(Ptr),         32'(p));
    endtask

    task automatic chk_idle(input string tag, input logic [2:0] t, input logic [15:0] d,
                            input logic [2:0] dst, input logic [2:0] p);
        chk({tag, ".confirm"}, 32'(CDB_confirm), 32'(0));
        chk({tag, ".valid"},   32'(CDB_valid),   32'(0));
        chk({tag, ".we"},      32'(CDB_we),      32'(0));
        chk({tag, ".tag"},     32'(CDB_tag),     32'(t));
        chk({tag, ".data"},    32'(CDB_data),    32'(d));
        chk({tag, ".dest"},    32'(CDB_dest),    32'(dst));
        chk({tag, ".ptr"},     32'(Ptr),         32'(p));
    endtask

    initial begin
        Reset    = 1'b0;
        Req      = 4'b1111;
        Result   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        R_target = {3'd6, 3'd2, 3'd7, 3'd4};

        // Reset held 3 cycles with every station requesting
        tick(); tick(); tick();
        chk_idle("reset", 3'd0, 16'h0000, 3'd0, 3'd0);

        // Release: all four rotate 0,1,2,3, each dropping Req after its confirm
        Reset = 1'b1;
        tick();
        chk_grant("rr0", 4'b0001, 3'd1, 16'h1111, 3'd4, 3'd1);
        Req = 4'b1110;
        tick();
        chk_grant("rr1", 4'b0010, 3'd2, 16'h2222, 3'd7, 3'd2);
        Req = 4'b1100;
        tick();
        chk_grant("rr2", 4'b0100, 3'd3, 16'h3333, 3'd2, 3'd3);
        Req = 4'b1000;
        tick();
        chk_grant("rr3", 4'b1000, 3'd4, 16'h4444, 3'd6, 3'd0);
        Req = 4'b0000;
        tick();
        chk_idle("rr_idle", 3'd4, 16'h4444, 3'd6, 3'd0);

        // Single request from station 2
        Result[47:32] = 16'h00A5;
        R_target[8:6] = 3'd5;
        Req = 4'b0100;
        tick();
        chk_grant("single", 4'b0100, 3'd3, 16'h00A5, 3'd5, 3'd3);
        Req = 4'b0000;
        tick();
        chk_idle("single_idle", 3'd3, 16'h00A5, 3'd5, 3'd3);

        // Ptr=3 with stations 3 and 0 requesting: 3 wins, pointer wraps, then 0
        Req = 4'b1001;
        tick();
        chk_grant("wrap3", 4'b1000, 3'd4, 16'h4444, 3'd6, 3'd0);
        Req = 4'b0001;
        tick();
        chk_grant("wrap0", 4'b0001, 3'd1, 16'h1111, 3'd4, 3'd1);
        Req = 4'b0000;
        tick();
        chk_idle("wrap_idle", 3'd1, 16'h1111, 3'd4, 3'd1);

        // Station 1 holds Req continuously: grants only every other cycle
        Req = 4'b0010;
        tick();
        chk_grant("hold_t0", 4'b0010, 3'd2, 16'h2222, 3'd7, 3'd2);
        tick();
        chk_idle("hold_t1", 3'd2, 16'h2222, 3'd7, 3'd2);
        tick();
        chk_grant("hold_t2", 4'b0010, 3'd2, 16'h2222, 3'd7, 3'd2);

        // Reset while confirm=0010 is high; station 1 keeps requesting
        Reset = 1'b0;
        tick();
        chk_idle("rst_mid", 3'd0, 16'h0000, 3'd0, 3'd0);
        Reset = 1'b1;
        tick();
        chk_grant("rst_regrant", 4'b0010, 3'd2, 16'h2222, 3'd7, 3'd2);
        Req = 4'b0000;
        tick();
        chk_idle("final_idle", 3'd2, 16'h2222, 3'd7, 3'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
